// File: rtl/encrypt_scheduler.sv
// Round-robin scheduler sharing one byte-encryption datapath between two NUL-terminated
// message requesters, with a key register that is only replaced between messages.
module encrypt_scheduler #(
    parameter int          MAX_LEN   = 64,
    parameter logic [7:0]  KEY_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    input  logic       key_load,
    input  logic [7:0] key_in,
    output logic       key_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_src,
    output logic       out_last,
    input  logic       out_ready,
    output logic       trunc
);

    localparam int LW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // NUL passes through unencrypted so the end-of-message marker survives.
    function automatic logic [7:0] enc_byte(input logic [7:0] m, input logic [7:0] k);
        logic [7:0] p;
        p = {m[7], ~m[6], m[1], ~m[4], m[5], ~m[2], m[3], ~m[0]};
        return (m == 8'h00) ? 8'h00 : (k ^ p);
    endfunction

    state_t          r_state;
    logic [7:0]      r_key;
    logic            r_rr_last;
    logic [LW-1:0]   r_len;
    logic            r_out_valid;
    logic [7:0]      r_out_data;
    logic            r_out_src;
    logic            r_out_last;
    logic            r_trunc;

    logic            w_out_free;
    logic            w_req0_ready;
    logic            w_req1_ready;
    logic            w_key_ready;
    logic            w_accept;
    logic [7:0]      w_byte;
    logic [LW-1:0]   w_len_inc;
    logic            w_at_max;
    logic            w_last;

    assign w_out_free = ~r_out_valid | out_ready;
    assign w_len_inc  = r_len + {{(LW-1){1'b0}}, 1'b1};
    assign w_at_max   = (w_len_inc == LW'(MAX_LEN));

    // Handshake readies and the byte currently offered by the granted requester.
    always_comb begin
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        w_key_ready  = 1'b0;
        w_accept     = 1'b0;
        w_byte       = 8'h00;
        if (reset) begin
            w_req0_ready = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_key_ready = ~r_out_valid;
                end
                GRANT0: begin
                    w_req0_ready = w_out_free;
                    w_accept     = req0_valid & w_out_free;
                    w_byte       = req0_data;
                end
                GRANT1: begin
                    w_req1_ready = w_out_free;
                    w_accept     = req1_valid & w_out_free;
                    w_byte       = req1_data;
                end
                default: begin
                    w_key_ready = 1'b0;
                end
            endcase
        end
    end

    assign w_last = (w_byte == 8'h00) | w_at_max;

    // Grant/key sequencing and the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_key       <= KEY_RESET;
            r_rr_last   <= 1'b1;
            r_len       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_src   <= 1'b0;
            r_out_last  <= 1'b0;
            r_trunc     <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= enc_byte(w_byte, r_key);
                r_out_src   <= (r_state == GRANT1);
                r_out_last  <= w_last;
                r_len       <= w_len_inc;
                r_trunc     <= w_at_max & (w_byte != 8'h00);
            end else if (r_out_valid & out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (key_load & w_key_ready) begin
                        r_key <= key_in;
                    end else if (req0_valid & (~req1_valid | r_rr_last)) begin
                        r_state   <= GRANT0;
                        r_rr_last <= 1'b0;
                        r_len     <= '0;
                    end else if (req1_valid) begin
                        r_state   <= GRANT1;
                        r_rr_last <= 1'b1;
                        r_len     <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GRANT0, GRANT1: begin
                    if (w_accept & w_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready = w_req0_ready;
    assign req1_ready = w_req1_ready;
    assign key_ready  = w_key_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_src    = r_out_src;
    assign out_last   = r_out_last;
    assign trunc      = r_trunc;

endmodule

// File: tb/tb_encrypt_scheduler.sv
// Directed bench for encrypt_scheduler (MAX_LEN=4) with hand-computed encrypted bytes.
module tb_encrypt_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid, key_load, out_ready;
    logic [7:0] req0_data, req1_data, key_in;
    logic       req0_ready, req1_ready, key_ready;
    logic       out_valid, out_src, out_last, trunc;
    logic [7:0] out_data;

    int n_vec = 0;
    int n_err = 0;

    encrypt_scheduler #(.MAX_LEN(4), .KEY_RESET(8'h00)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .key_load(key_load), .key_in(key_in), .key_ready(key_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_last(out_last), .out_ready(out_ready), .trunc(trunc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                           input logic s, input logic l);
        chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
        chk({tag, ".data"},  out_data, d);
        chk({tag, ".src"},   {7'd0, out_src}, {7'd0, s});
        chk({tag, ".last"},  {7'd0, out_last}, {7'd0, l});
    endtask

    initial begin
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; key_load = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00; key_in = 8'h00; out_ready = 1'b1;
        tick(); tick();
        chk_out("rst", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst.key_ready", {7'd0, key_ready}, 8'd0);
        chk("rst.req0_ready", {7'd0, req0_ready}, 8'd0);
        chk("rst.trunc", {7'd0, trunc}, 8'd0);
        reset = 1'b0; #1;
        chk("idle.key_ready", {7'd0, key_ready}, 8'd1);

        // key load 0x5A, then "A\0" from req0
        key_load = 1'b1; key_in = 8'h5A;
        tick();
        key_load = 1'b0; req0_valid = 1'b1; req0_data = 8'h41;
        chk("kl.req0_ready_idle", {7'd0, req0_ready}, 8'd0);
        tick();
        chk("g0.req0_ready", {7'd0, req0_ready}, 8'd1);
        tick();
        chk_out("A", 1'b1, 8'h4E, 1'b0, 1'b0);
        req0_data = 8'h00;
        tick();
        chk_out("A.nul", 1'b1, 8'h00, 1'b0, 1'b1);
        req0_valid = 1'b0;
        tick();
        chk("A.drain", {7'd0, out_valid}, 8'd0);

        // alternation from a fresh reset
        reset = 1'b1; tick(); reset = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h42; req1_valid = 1'b1; req1_data = 8'h61;
        tick();
        chk("rr1.req0_ready", {7'd0, req0_ready}, 8'd1);
        chk("rr1.req1_ready", {7'd0, req1_ready}, 8'd0);
        tick();
        chk_out("B", 1'b1, 8'h35, 1'b0, 1'b0);
        req0_data = 8'h00;
        tick();
        chk_out("B.nul", 1'b1, 8'h00, 1'b0, 1'b1);
        req0_valid = 1'b0;
        tick();
        chk("rr2.req1_ready", {7'd0, req1_ready}, 8'd1);
        chk("rr2.req0_ready", {7'd0, req0_ready}, 8'd0);
        tick();
        chk_out("a", 1'b1, 8'h1C, 1'b1, 1'b0);
        req1_data = 8'h00;
        tick();
        chk_out("a.nul", 1'b1, 8'h00, 1'b1, 1'b1);
        req0_valid = 1'b1; req0_data = 8'h43; req1_data = 8'h80;
        tick();
        chk("rr3.req0_ready", {7'd0, req0_ready}, 8'd1);
        chk("rr3.req1_ready", {7'd0, req1_ready}, 8'd0);
        tick();
        chk_out("C", 1'b1, 8'h34, 1'b0, 1'b0);

        // back-pressure for three cycles
        out_ready = 1'b0; req0_data = 8'h42; #1;
        chk("bp.req0_ready", {7'd0, req0_ready}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp.hold", 1'b1, 8'h34, 1'b0, 1'b0);
            chk("bp.ready_low", {7'd0, req0_ready}, 8'd0);
        end
        out_ready = 1'b1; #1;
        chk("bp.release_ready", {7'd0, req0_ready}, 8'd1);
        tick();
        chk_out("bp.next", 1'b1, 8'h35, 1'b0, 1'b0);
        req0_data = 8'h00;
        tick();
        chk_out("bp.nul", 1'b1, 8'h00, 1'b0, 1'b1);
        req0_valid = 1'b0;
        tick();

        // key_load while GRANT1 is active
        key_load = 1'b1; key_in = 8'h33; #1;
        chk("g1.key_ready", {7'd0, key_ready}, 8'd0);
        tick();
        chk_out("oldkey", 1'b1, 8'hD5, 1'b1, 1'b0);
        chk("g1.key_ready2", {7'd0, key_ready}, 8'd0);
        req1_data = 8'h00;
        tick();
        chk_out("oldkey.nul", 1'b1, 8'h00, 1'b1, 1'b1);
        chk("idle_busy.key_ready", {7'd0, key_ready}, 8'd0);
        req1_valid = 1'b0;
        tick();
        chk("idle_free.key_ready", {7'd0, key_ready}, 8'd1);
        tick();
        key_load = 1'b0; req1_valid = 1'b1; req1_data = 8'h80;
        tick();
        tick();
        chk_out("newkey", 1'b1, 8'hE6, 1'b1, 1'b0);
        req1_data = 8'h00;
        tick();
        req1_valid = 1'b0;
        tick();

        // MAX_LEN truncation with req1 waiting
        req0_valid = 1'b1; req0_data = 8'h31; req1_valid = 1'b1; req1_data = 8'h61;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("tr.body", 1'b1, 8'h7F, 1'b0, 1'b0);
            chk("tr.no_pulse", {7'd0, trunc}, 8'd0);
        end
        tick();
        chk_out("tr.4th", 1'b1, 8'h7F, 1'b0, 1'b1);
        chk("tr.pulse", {7'd0, trunc}, 8'd1);
        tick();
        chk("tr.pulse_end", {7'd0, trunc}, 8'd0);
        chk("tr.req1_ready", {7'd0, req1_ready}, 8'd1);
        chk("tr.req0_ready", {7'd0, req0_ready}, 8'd0);
        tick();
        chk_out("tr.req1", 1'b1, 8'h2F, 1'b1, 1'b0);
        req1_data = 8'h00;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // asynchronous reset with a byte in the output register
        req0_valid = 1'b1; req0_data = 8'h42; out_ready = 1'b0;
        tick();
        tick();
        chk("ar.pre_valid", {7'd0, out_valid}, 8'd1);
        #2 reset = 1'b1; #1;
        chk_out("ar.async", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("ar.req0_ready", {7'd0, req0_ready}, 8'd0);
        req0_valid = 1'b0; out_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("ar.quiet", {7'd0, out_valid}, 8'd0);
        req1_valid = 1'b1; req1_data = 8'h80;
        tick();
        tick();
        chk_out("ar.keyreset", 1'b1, 8'hD5, 1'b1, 1'b0);
        req1_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
